// File: rtl/ram_arbiter.sv
// Arbiter that shares one single-port registered-read RAM between instruction fetch and the data stage.
// Data requests have priority, but fetch is forced through after a run of contended data grants.
//
// rsp_owner | meaning
// ----------+-------------------------------------------------------
// RSP_NONE  | no read was issued last cycle, so no response is due
// RSP_IF    | a fetch read was issued last cycle; ram_q goes to fetch
// RSP_DM    | a data read was issued last cycle; ram_q goes to data
module ram_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    rsp_t              r_rsp_owner;
    rsp_t              w_rsp_next;
    logic [3:0]        r_streak;
    logic [3:0]        w_streak_next;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              w_if_gnt;
    logic              w_dm_gnt;

    // Grants are gated by reset so nothing reaches the RAM while reset is held.
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (rst_n) begin
            if (dm_req && (!if_req || (r_streak < STREAK_MAX))) begin
                w_dm_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_data  = '0;
        ram_wr_en = 1'b0;
        if (w_dm_gnt) begin
            ram_addr  = dm_addr;
            ram_data  = dm_wdata;
            ram_wr_en = dm_we;
        end else if (w_if_gnt) begin
            ram_addr  = if_addr;
        end
    end

    always_comb begin
        w_streak_next = 4'd0;
        if (w_dm_gnt && if_req) begin
            w_streak_next = (r_streak >= STREAK_MAX) ? STREAK_MAX : r_streak + 4'd1;
        end
    end

    always_comb begin
        w_rsp_next = RSP_NONE;
        if (w_if_gnt) begin
            w_rsp_next = RSP_IF;
        end else if (w_dm_gnt && !dm_we) begin
            w_rsp_next = RSP_DM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_owner <= RSP_NONE;
            r_streak    <= 4'd0;
        end else begin
            r_rsp_owner <= w_rsp_next;
            r_streak    <= w_streak_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (r_rsp_owner == RSP_IF) r_if_rdata <= ram_q;
            if (r_rsp_owner == RSP_DM) r_dm_rdata <= ram_q;
        end
    end

    // During the response cycle ram_q is forwarded directly; afterwards the captured copy holds.
    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    assign if_rvalid = (r_rsp_owner == RSP_IF);
    assign dm_rvalid = (r_rsp_owner == RSP_DM);
    assign if_rdata  = if_rvalid ? ram_q : r_if_rdata;
    assign dm_rdata  = dm_rvalid ? ram_q : r_dm_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 256x32 registered-read RAM.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_wr_en;
    logic [31:0] ram_q;

    logic [31:0] mem [256];
    logic        init_done;

    int n_checks;
    int n_fail;

    ram_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_DM_STREAK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_wr_en (ram_wr_en),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        return (a == 5) ? 32'hDEADBEEF : (32'hA5000000 | 32'(a));
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (ram_wr_en) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        logic exp_dm [10];
        logic prev_dm;
        n_checks  = 0;
        n_fail    = 0;
        init_done = 1'b0;
        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 8'd5;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = 8'd0;
        dm_wdata  = 32'd0;
        @(posedge clk);
        #1 init_done = 1'b1;
        @(posedge clk);
        #3;
        check("rst_if_gnt",    32'(if_gnt), 0);
        check("rst_dm_gnt",    32'(dm_gnt), 0);
        check("rst_wr_en",     32'(ram_wr_en), 0);
        check("rst_ram_addr",  32'(ram_addr), 0);
        check("rst_if_rvalid", 32'(if_rvalid), 0);
        check("rst_if_rdata",  if_rdata, 0);
        check("rst_dm_rdata",  dm_rdata, 0);

        // Single fetch of address 5, released straight out of reset.
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("fetch_gnt",      32'(if_gnt), 1);
        check("fetch_dm_gnt",   32'(dm_gnt), 0);
        check("fetch_ram_addr", 32'(ram_addr), 5);
        check("fetch_ram_data", ram_data, 0);
        next_cycle();
        if_req = 1'b0;
        #1;
        check("fetch_rvalid",  32'(if_rvalid), 1);
        check("fetch_rdata",   if_rdata, 32'hDEADBEEF);
        check("fetch_gnt_off", 32'(if_gnt), 0);
        next_cycle();
        #1;
        check("fetch_rvalid_off", 32'(if_rvalid), 0);
        check("fetch_rdata_hold", if_rdata, 32'hDEADBEEF);

        // Data write to 9, then read it back in the next cycle.
        next_cycle();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'd9; dm_wdata = 32'h12345678;
        #1;
        check("wr_gnt",      32'(dm_gnt), 1);
        check("wr_en",       32'(ram_wr_en), 1);
        check("wr_ram_addr", 32'(ram_addr), 9);
        check("wr_ram_data", ram_data, 32'h12345678);
        next_cycle();
        dm_we = 1'b0; dm_wdata = 32'h0;
        #1;
        check("rd_gnt",         32'(dm_gnt), 1);
        check("rd_wr_en",       32'(ram_wr_en), 0);
        check("wr_no_rvalid",   32'(dm_rvalid), 0);
        next_cycle();
        dm_req = 1'b0;
        #1;
        check("rd_rvalid", 32'(dm_rvalid), 1);
        check("rd_rdata",  dm_rdata, 32'h12345678);
        next_cycle();
        #1;
        check("rd_rvalid_off", 32'(dm_rvalid), 0);
        check("rd_rdata_hold", dm_rdata, 32'h12345678);

        // Contention with streak limit 4.
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        prev_dm = 1'b0;
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            if (i < 10) begin
                if_req = 1'b1; if_addr = 8'd30;
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'd20;
            end else begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            #1;
            if (i < 10) begin
                check($sformatf("cont_dm_gnt%0d", i), 32'(dm_gnt), 32'(exp_dm[i]));
                check($sformatf("cont_if_gnt%0d", i), 32'(if_gnt), 32'(!exp_dm[i]));
            end
            if (i > 0) begin
                check($sformatf("cont_dm_rv%0d", i), 32'(dm_rvalid), 32'(prev_dm));
                check($sformatf("cont_if_rv%0d", i), 32'(if_rvalid), 32'(!prev_dm));
                if (prev_dm) check($sformatf("cont_dm_rd%0d", i), dm_rdata, 32'hA5000014);
                else         check($sformatf("cont_if_rd%0d", i), if_rdata, 32'hA500001E);
            end
            if (i < 10) prev_dm = exp_dm[i];
        end

        // Back-to-back fetches of 0..3.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i < 4) begin
                if_req = 1'b1; if_addr = 8'(i);
            end else begin
                if_req = 1'b0;
            end
            #1;
            if (i < 4) begin
                check($sformatf("b2b_gnt%0d", i),  32'(if_gnt), 1);
                check($sformatf("b2b_addr%0d", i), 32'(ram_addr), 32'(i));
            end
            if (i > 0) begin
                check($sformatf("b2b_rv%0d", i), 32'(if_rvalid), 1);
                check($sformatf("b2b_rd%0d", i), if_rdata, init_word(i - 1));
            end
        end

        // Reset in the response cycle of a data read drops the response.
        next_cycle();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'd9;
        #1;
        check("rrst_gnt", 32'(dm_gnt), 1);
        next_cycle();
        dm_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rrst_rvalid", 32'(dm_rvalid), 0);
        check("rrst_rdata",  dm_rdata, 0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("rrst_rvalid_rel", 32'(dm_rvalid), 0);
        check("rrst_rdata_rel",  dm_rdata, 0);
        next_cycle();
        #1;
        check("rrst_rvalid_after", 32'(dm_rvalid), 0);
        check("rrst_rdata_after",  dm_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 256x32 program/data RAM between the instruction-fetch unit (read-only) and the data-memory stage (read/write).
- At most one RAM access is issued per clock.
- Data accesses win contention, subject to an anti-starvation limit for fetch.
- Read data is routed back to the owning requester one cycle after grant, matching the RAM's registered read port.

Parameters:
ADDR_W, 8, RAM word-address width.
DATA_W, 32, RAM data width.
MAX_DM_STREAK, 4, consecutive contended data grants allowed before fetch is forced through (legal 1..15).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch read request; held with if_addr stable until if_gnt
if_addr  input  ADDR_W  fetch word address
if_gnt  output  1  fetch access issued this cycle (combinational)
if_rvalid  output  1  fetch read data valid this cycle
if_rdata  output  DATA_W  fetch read data; holds last delivered value
dm_req  input  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_gnt
dm_we  input  1  1 = write, 0 = read
dm_addr  input  ADDR_W  data word address
dm_wdata  input  DATA_W  write data
dm_gnt  output  1  data access issued this cycle (combinational)
dm_rvalid  output  1  data read data valid this cycle (never for writes)
dm_rdata  output  DATA_W  data read data; holds last delivered value
ram_addr  output  ADDR_W  to RAM addr
ram_data  output  DATA_W  to RAM data
ram_wr_en  output  1  to RAM wr_en
ram_q  input  DATA_W  from RAM q (valid the cycle after a read issue)

Behaviour:
- Reset (async assert, sync release): rsp_owner=NONE, streak=0, if_rvalid=dm_rvalid=0, if_rdata=dm_rdata=0.
  - Outputs during reset: gnts 0, ram_wr_en 0, ram_addr 0, ram_data 0.
  - Reset mid-read drops the pending response; no rvalid follows.
- Arbitration (combinational, every cycle; at most one of if_gnt, dm_gnt high):
  - dm_req only -> dm_gnt.
  - if_req only -> if_gnt.
  - Both -> dm_gnt if streak < MAX_DM_STREAK, else if_gnt.
- RAM drive:
  - dm grant: ram_addr=dm_addr, ram_wr_en=dm_we, ram_data=dm_wdata.
  - if grant: ram_addr=if_addr, ram_wr_en=0, ram_data=0.
  - No grant: ram_addr=0, ram_wr_en=0, ram_data=0 (harmless read; no response generated).
- Streak counter, 4 bits:
  - dm grant while if_req=1: +1, saturating at MAX_DM_STREAK.
  - if grant, or if_req=0: cleared to 0.
- Response FSM, register rsp_owner in {NONE, IF, DM}, loaded every cycle:
  - IF on an if grant; DM on a dm read grant; NONE on a dm write or no grant.
  - In the cycle after the grant, rsp_owner=IF -> if_rvalid=1, if_rdata=ram_q. rsp_owner=DM -> dm_rvalid=1, dm_rdata=ram_q.
  - Each rdata register captures ram_q at the end of its rvalid cycle and holds it until the next rvalid for that port.
- Throughput and latency:
  - A new grant may issue in the same cycle as an rvalid, so back-to-back reads sustain one per cycle.
  - Read latency is 1 cycle from gnt to rvalid.
  - A write completes at the gnt edge.
- Write then read of the same address in consecutive cycles returns the new data. The RAM write lands at the first edge; the read issues at the next.
- Requester must not change request fields while req=1 and gnt=0. Deasserting req before gnt is allowed and cancels the request.

Test Plan:
- Reset: rst_n=0 mid-cycle with if_req=1 -> gnts, rvalids and ram_wr_en 0 immediately; rdata=0; after release, first grant occurs on the next edge.
- Single fetch: mem[5]=32'hDEADBEEF, if_req=1 addr 5 for one cycle -> if_gnt same cycle, ram_addr=5; next cycle if_rvalid=1, if_rdata=32'hDEADBEEF; if_rdata holds afterward.
- Data write then read: dm write addr 9 data 32'h12345678, then dm read addr 9 -> ram_wr_en=1 for one cycle only; dm_rvalid one cycle after the read grant with 32'h12345678; no dm_rvalid for the write.
- Contention: if_req and dm_req (reads) both held continuously, MAX_DM_STREAK=4 -> grant sequence DM,DM,DM,DM,IF,DM,DM,DM,DM,IF; rvalids alternate accordingly with correct data.
- Back-to-back fetch of addrs 0..3 -> if_gnt on 4 consecutive cycles; if_rvalid on the 4 following cycles (overlapping) with mem[0..3] in order.
- Reset asserted in the cycle after a dm read grant -> no dm_rvalid; dm_rdata=0.
